// File: rtl/seq_window_ctrl.sv
// seq_window_ctrl: windowed serial pattern-scan controller.
// A start in IDLE latches the pattern and window length. The block then shifts
// exactly win_len qualified bits through a PAT_W-bit matcher. Matches are
// counted with saturation, and done pulses once when the window completes.
// Optional build macro: SEQ_OVERLAP_EN
//   defined   - overlapping matches allowed; shift history kept after a match
//   undefined - history cleared on a match; next match needs PAT_W fresh bits
module seq_window_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] win_len,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    localparam int               HIST_W   = $clog2(PAT_W + 1);
    localparam logic [HIST_W-1:0] HIST_MAX = HIST_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  shreg;
    logic [PAT_W-1:0]  sh_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  nbits;
    logic [LEN_W-1:0]  nbits_nxt;
    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_nxt;
    logic              hit;
    logic              last_bit;

    // Next-value datapath for the bit being accepted this cycle.
    always_comb begin
        sh_nxt    = {shreg[PAT_W-2:0], in};
        nbits_nxt = nbits + LEN_W'(1);
        hist_nxt  = (hist == HIST_MAX) ? hist : hist + HIST_W'(1);
        // A match needs PAT_W bits of history, including the incoming bit.
        hit       = (hist >= HIST_MAX - HIST_W'(1)) && (sh_nxt == pat_q);
        last_bit  = (nbits_nxt == len_q);
    end

    // Scan sequencer: IDLE -> RUN -> DONE -> IDLE, with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            shreg       <= '0;
            hist        <= '0;
            nbits       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        len_q       <= win_len;
                        shreg       <= '0;
                        hist        <= '0;
                        nbits       <= '0;
                        match_count <= '0;
                        overflow    <= 1'b0;
                        // An empty window completes immediately and never
                        // raises busy.
                        if (win_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Without in_valid, nothing changes and the scan stalls.
                    if (in_valid) begin
                        shreg <= sh_nxt;
                        nbits <= nbits_nxt;
                        hist  <= hist_nxt;
                        if (hit) begin
                            match <= 1'b1;
                            if (match_count == CNT_MAX)
                                overflow <= 1'b1;
                            else
                                match_count <= match_count + CNT_W'(1);
`ifndef SEQ_OVERLAP_EN
                            hist <= '0;
`endif
                        end
                        // A match on the final bit is still counted above.
                        if (last_bit) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_window_ctrl.md
# seq_window_ctrl

Windowed serial pattern-scan controller. On a `start` handshake it latches a programmable bit pattern and window length, shifts exactly `win_len` qualified serial bits through a pattern matcher, counts matches with saturation, and signals completion. It sits in front of the serial detection path and sequences each detection run, replacing free-running detection with bounded, software-configured scans.

## Interface
- `PAT_W`, 4: pattern length in bits, 2..8.
- `CNT_W`, 4: match counter width.
- `LEN_W`, 8: window length counter width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `start`  in  1  begin a scan; sampled only in IDLE.
- `pattern`  in  PAT_W  target pattern, MSB is the oldest bit; latched on start.
- `win_len`  in  LEN_W  number of qualified bits to scan; latched on start.
- `in_valid`  in  1  qualifies `in` this cycle.
- `in`  in  1  serial data bit.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at end of scan.
- `match`  out  1  one-cycle pulse per detected match.
- `match_count`  out  CNT_W  matches in current or last scan.
- `overflow`  out  1  sticky, set when a match occurs with the count already saturated.

## Operation
- States: IDLE, RUN, DONE. All state and outputs are registered.
- IDLE: if `start` is high, latch `pattern` and `win_len`, then clear the shift register, the history count `hist`, the bit count `nbits`, `match_count` and `overflow`.
  - If the latched `win_len`==0, go to DONE. Otherwise go to RUN.
- RUN: each cycle with `in_valid`=1:
  - `shreg <= {shreg[PAT_W-2:0], in}`.
  - `hist` increments and saturates at PAT_W.
  - `nbits` increments.
- Match condition: `hist`+1 >= PAT_W and the new shreg value equals the latched pattern.
  - On a match, `match` pulses and `match_count` increments.
  - At 2^CNT_W-1 the count holds and `overflow` sets.
- When the accepted bit makes `nbits`==`win_len`, go to DONE. Any match on that bit is still counted.
- `in_valid`=0 in RUN: no change; the scan stalls indefinitely.
- DONE: `done`=1 for one cycle, then IDLE. `match_count` and `overflow` hold until the next start.
- `start` in RUN or DONE is ignored. `in_valid` and `in` outside RUN are ignored.
- Changes to `pattern` or `win_len` after the start cycle have no effect.

## Timing
- Reset, held while `rst`=0: state IDLE; `busy`, `done`, `match`, `match_count`, `overflow`, `shreg`, `hist` and `nbits` all 0.
- Reset mid-scan aborts the scan: no `done`, and the count is lost.
- `start` at cycle T: `busy`=1 from T+1. If `win_len`==0: `done`=1 at T+1 and `busy` stays 0.
- Bit accepted at cycle t: `match` and the updated `match_count`/`overflow` are visible at t+1.
- Last bit accepted at t: `busy`=0 and `done`=1 at t+1, coincident with that bit's `match`. IDLE at t+2.
- A new `start` is accepted at t+2 at the earliest.
- Throughput: one bit per cycle, with no bubbles between consecutive bits.

## Configuration
- `SEQ_OVERLAP_EN` defined: overlapping matches are allowed, and shift history is kept after a match.
- `SEQ_OVERLAP_EN` undefined:
  - On a match, `hist` is cleared to 0, so the next match requires PAT_W fresh bits.
  - `shreg` contents are irrelevant until `hist` refills.

## Test plan
- PAT_W=4, pattern=4'b1011, win_len=7, stream 1,0,1,1,0,1,1 at one bit per cycle. Required response:
  - With `SEQ_OVERLAP_EN`: `match` after bits 4 and 7, `match_count`=2.
  - Without `SEQ_OVERLAP_EN`: match after bit 4 only, `match_count`=1.
  - In both cases `done` pulses one cycle after bit 7.
- CNT_W=4, pattern=4'b1111, win_len=20, all ones, `SEQ_OVERLAP_EN` defined:
  - 17 matches occur; `match_count` saturates at 15.
  - `overflow`=1 from the 16th match onward; after `done` both hold.
- win_len=0, start pulse at T: `done`=1 at T+1, `busy` never high, `match_count`=0.
- Scan with `in_valid` toggled 1,0,0,1,...:
  - Only qualified bits count toward `win_len` and matching.
  - `start` and a changed `pattern` applied mid-RUN have no effect.
- `rst`=0 for one cycle mid-RUN:
  - Next cycle: IDLE with all outputs 0 and no `done`.
  - A following start runs a clean scan.
- Pattern straddling the start: bits 1,0,1 fed before start and 1 after, with `in_valid` high throughout: no match, since history cleared at start.
